// File: rtl/cache_miss_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_fill_ctrl
//
// Purpose:
//   Per-thread cache miss handler. Each hardware thread owns a small FSM
//   (IDLE -> LOOKUP -> REQ -> WAIT -> FILL -> IDLE) that:
//     - asks the set-LRU for a victim way,
//     - sends a line request to main memory,
//     - waits for the tagged line response, which may arrive in any order,
//     - emits one fill beat. The same beat drives the LRU second-thread
//       update port.
//   The three shared ports (victim lookup, memory request and fill) each have
//   their own round-robin arbiter. The thread that was granted becomes the
//   lowest priority on the next cycle.
//
// Ports:
//   clock, reset            core clock (rising edge), async active-low reset
//   mt_mode                 single- or multi-threaded operation
//   miss_req/miss_addr      per-thread miss request and byte address
//   miss_busy/miss_done     per-thread FSM-not-idle flag, and a done pulse
//                           coincident with the thread's fill beat
//   victim_*                LRU victim lookup; victim_way is returned
//                           combinationally in the same cycle
//   mem_req_*               line request with valid/ready handshake
//   mem_rsp_*               tagged line response, no backpressure
//   fill_*                  fill beat / LRU update
//   rsp_err                 sticky flag: a response arrived for a thread that
//                           was not waiting for one
// -----------------------------------------------------------------------------

package cache_miss_fill_ctrl_pkg;

  typedef enum logic {
    SINGLE_THREADED = 1'b0,
    MULTI_THREADED  = 1'b1
  } multithreading_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FILL   = 3'd4
  } miss_state_t;

endpackage

module cache_miss_fill_ctrl
  import cache_miss_fill_ctrl_pkg::*;
#(
  parameter int NUM_SET      = 4,
  parameter int WAYS_PER_SET = 4,
  parameter int NUM_THREADS  = 2,
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int OFFSET_W     = 4,
  localparam int NUM_SET_W      = $clog2(NUM_SET),
  localparam int WAYS_PER_SET_W = $clog2(WAYS_PER_SET),
  localparam int THR_W          = $clog2(NUM_THREADS),
  localparam int TAG_W          = ADDR_W - OFFSET_W - NUM_SET_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  multithreading_mode_t          mt_mode,
  input  logic [NUM_THREADS-1:0]        miss_req,
  input  logic [NUM_THREADS*ADDR_W-1:0] miss_addr,
  output logic [NUM_THREADS-1:0]        miss_busy,
  output logic [NUM_THREADS-1:0]        miss_done,
  output logic                          victim_req,
  output logic [NUM_SET_W-1:0]          victim_set,
  output logic [THR_W-1:0]              victim_thread,
  input  logic [WAYS_PER_SET_W-1:0]     victim_way,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  output logic [THR_W-1:0]              mem_req_thread,
  input  logic                          mem_rsp_valid,
  input  logic [THR_W-1:0]              mem_rsp_thread,
  input  logic [LINE_W-1:0]             mem_rsp_data,
  output logic                          fill_valid,
  output logic [NUM_SET_W-1:0]          fill_set,
  output logic [WAYS_PER_SET_W-1:0]     fill_way,
  output logic [THR_W-1:0]              fill_thread,
  output logic [TAG_W-1:0]              fill_tag,
  output logic [LINE_W-1:0]             fill_data,
  output logic                          rsp_err
);

  // Only the line address (byte address without the offset) is kept per thread.
  // Its low NUM_SET_W bits are the set index and the rest is the tag.
  localparam int LA_W = ADDR_W - OFFSET_W;

  // ---------------------------------------------------------------------------
  // Per-thread state
  // ---------------------------------------------------------------------------
  miss_state_t                r_state [NUM_THREADS];
  logic [LA_W-1:0]            r_laddr [NUM_THREADS];
  logic [WAYS_PER_SET_W-1:0]  r_way   [NUM_THREADS];
  logic [LINE_W-1:0]          r_line  [NUM_THREADS];

  // Round-robin pointers: each points at the thread with the highest priority.
  logic [THR_W-1:0]           r_vic_ptr;
  logic [THR_W-1:0]           r_mem_ptr;
  logic [THR_W-1:0]           r_fill_ptr;

  // While a memory request is stalled (valid && !ready), the grant is pinned
  // to the stalled thread so that addr and thread stay stable.
  logic                       r_mem_lock;
  logic [THR_W-1:0]           r_mem_lock_thr;

  logic                       r_rsp_err;

  // ---------------------------------------------------------------------------
  // Arbitration helpers
  // ---------------------------------------------------------------------------
  // Picks the first requester, starting at ptr and wrapping around. Doubling
  // the request vector turns the wrap into a plain right shift.
  function automatic logic [THR_W-1:0] rr_pick(input logic [NUM_THREADS-1:0] req,
                                                input logic [THR_W-1:0]       ptr);
    logic [2*NUM_THREADS-1:0] dbl;
    logic                     found;
    logic [THR_W-1:0]         pick;
    int                       idx;
    dbl   = {req, req} >> ptr;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!found && dbl[i]) begin
        found = 1'b1;
        idx   = (int'(ptr) + i) % NUM_THREADS;
        pick  = THR_W'(idx);
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // Pointer value after granting g: the thread after g gets top priority.
  function automatic logic [THR_W-1:0] rr_next(input logic [THR_W-1:0] g);
    int nxt;
    nxt = (int'(g) + 1) % NUM_THREADS;
    return THR_W'(nxt);
  endfunction

  // ---------------------------------------------------------------------------
  // Request vectors and response matching
  // ---------------------------------------------------------------------------
  logic [NUM_THREADS-1:0] w_vic_reqs;
  logic [NUM_THREADS-1:0] w_mem_reqs;
  logic [NUM_THREADS-1:0] w_fill_reqs;
  logic                   w_rsp_hit;
  logic [NUM_THREADS-1:0] w_accept_mask;
  logic                   w_unused_low_bits;

  // Build the per-port request vectors, and find out whether the response
  // belongs to a thread that is waiting for it.
  always_comb begin
    w_vic_reqs        = '0;
    w_mem_reqs        = '0;
    w_fill_reqs       = '0;
    w_rsp_hit         = 1'b0;
    w_unused_low_bits = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_vic_reqs[t]     = (r_state[t] == ST_LOOKUP);
      w_mem_reqs[t]     = (r_state[t] == ST_REQ);
      w_fill_reqs[t]    = (r_state[t] == ST_FILL);
      w_unused_low_bits = w_unused_low_bits ^ (^miss_addr[t*ADDR_W +: OFFSET_W]);
      if (mem_rsp_valid && (mem_rsp_thread == THR_W'(t)) && (r_state[t] == ST_WAIT)) begin
        w_rsp_hit = 1'b1;
      end else begin
        w_rsp_hit = w_rsp_hit;
      end
    end
  end

  // In single-threaded mode only thread 0 may start a miss.
  assign w_accept_mask = (mt_mode == MULTI_THREADED) ? {NUM_THREADS{1'b1}}
                                                     : NUM_THREADS'(1'b1);

  // ---------------------------------------------------------------------------
  // Fill port: evaluated first, because it can hold off a victim lookup
  // ---------------------------------------------------------------------------
  logic                      w_fill_any;
  logic [THR_W-1:0]          w_fill_pick;
  logic [NUM_SET_W-1:0]      w_fill_set;

  assign w_fill_any  = |w_fill_reqs;
  assign w_fill_pick = rr_pick(w_fill_reqs, r_fill_ptr);
  assign w_fill_set  = r_laddr[w_fill_pick][NUM_SET_W-1:0];

  // ---------------------------------------------------------------------------
  // Victim port. When the winning lookup targets the same set as this cycle's
  // fill, the fill wins: the LRU for that set is being updated. The lookup
  // then retries next cycle, and its pointer does not move.
  // ---------------------------------------------------------------------------
  logic                      w_vic_pick_valid;
  logic [THR_W-1:0]          w_vic_pick;
  logic [NUM_SET_W-1:0]      w_vic_set;
  logic                      w_vic_grant;

  assign w_vic_pick_valid = |w_vic_reqs;
  assign w_vic_pick       = rr_pick(w_vic_reqs, r_vic_ptr);
  assign w_vic_set        = r_laddr[w_vic_pick][NUM_SET_W-1:0];
  assign w_vic_grant      = w_vic_pick_valid && !(w_fill_any && (w_fill_set == w_vic_set));

  // ---------------------------------------------------------------------------
  // Memory request port
  // ---------------------------------------------------------------------------
  logic                      w_mem_grant;
  logic [THR_W-1:0]          w_mem_pick;
  logic                      w_mem_fire;

  assign w_mem_grant = |w_mem_reqs;
  assign w_mem_pick  = r_mem_lock ? r_mem_lock_thr : rr_pick(w_mem_reqs, r_mem_ptr);
  assign w_mem_fire  = w_mem_grant && mem_req_ready;

  // ---------------------------------------------------------------------------
  // Per-thread FSMs, arbiter pointers, stall lock and sticky error
  // ---------------------------------------------------------------------------
  // Advance every thread FSM and update the shared arbitration state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_state[t] <= ST_IDLE;
        r_laddr[t] <= '0;
        r_way[t]   <= '0;
        r_line[t]  <= '0;
      end
      r_vic_ptr      <= '0;
      r_mem_ptr      <= '0;
      r_fill_ptr     <= '0;
      r_mem_lock     <= 1'b0;
      r_mem_lock_thr <= '0;
      r_rsp_err      <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        case (r_state[t])
          ST_IDLE: begin
            if (miss_req[t] && w_accept_mask[t]) begin
              r_laddr[t] <= miss_addr[t*ADDR_W + OFFSET_W +: LA_W];
              r_state[t] <= ST_LOOKUP;
            end
          end
          ST_LOOKUP: begin
            if (w_vic_grant && (w_vic_pick == THR_W'(t))) begin
              r_way[t]   <= victim_way;
              r_state[t] <= ST_REQ;
            end
          end
          ST_REQ: begin
            if (w_mem_fire && (w_mem_pick == THR_W'(t))) begin
              r_state[t] <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (mem_rsp_valid && (mem_rsp_thread == THR_W'(t))) begin
              r_line[t]  <= mem_rsp_data;
              r_state[t] <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (w_fill_any && (w_fill_pick == THR_W'(t))) begin
              r_state[t] <= ST_IDLE;
            end
          end
          default: begin
            r_state[t] <= ST_IDLE;
          end
        endcase
      end

      if (w_vic_grant) begin
        r_vic_ptr <= rr_next(w_vic_pick);
      end
      if (w_mem_fire) begin
        r_mem_ptr <= rr_next(w_mem_pick);
      end
      if (w_fill_any) begin
        r_fill_ptr <= rr_next(w_fill_pick);
      end

      r_mem_lock     <= w_mem_grant && !mem_req_ready;
      r_mem_lock_thr <= w_mem_pick;

      // A response nobody is waiting for is dropped; only the flag records it.
      if (mem_rsp_valid && !w_rsp_hit) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registered state and the arbiter picks. Data fields
  // are forced to zero when their strobe is low.
  // ---------------------------------------------------------------------------
  // Per-thread busy and done flags.
  always_comb begin
    miss_busy = '0;
    miss_done = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      miss_busy[t] = (r_state[t] != ST_IDLE);
      miss_done[t] = w_fill_any && (w_fill_pick == THR_W'(t));
    end
  end

  assign victim_req     = w_vic_grant;
  assign victim_set     = w_vic_grant ? w_vic_set  : '0;
  assign victim_thread  = w_vic_grant ? w_vic_pick : '0;

  assign mem_req_valid  = w_mem_grant;
  assign mem_req_addr   = w_mem_grant ? {r_laddr[w_mem_pick], {OFFSET_W{1'b0}}} : '0;
  assign mem_req_thread = w_mem_grant ? w_mem_pick : '0;

  assign fill_valid     = w_fill_any;
  assign fill_set       = w_fill_any ? w_fill_set : '0;
  assign fill_way       = w_fill_any ? r_way[w_fill_pick] : '0;
  assign fill_thread    = w_fill_any ? w_fill_pick : '0;
  assign fill_tag       = w_fill_any ? r_laddr[w_fill_pick][LA_W-1 -: TAG_W] : '0;
  assign fill_data      = w_fill_any ? r_line[w_fill_pick] : '0;

  assign rsp_err        = r_rsp_err;

endmodule

// File: tb/tb_cache_miss_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_miss_fill_ctrl
//
// Scoreboard bench for cache_miss_fill_ctrl. Each directed scenario pushes the
// beats it expects (cycle, set, way, tag, thread, data) into one queue per
// output port. A monitor running on the falling edge pops an entry whenever
// the DUT presents a victim lookup, a completed memory handshake or a fill
// beat, and compares the two.
// -----------------------------------------------------------------------------
module tb_cache_miss_fill_ctrl;
  import cache_miss_fill_ctrl_pkg::*;

  localparam int NT     = 2;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int SET_W  = 2;
  localparam int WAY_W  = 2;
  localparam int THR_W  = 1;
  localparam int TAG_W  = 26;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  multithreading_mode_t   mt_mode;
  logic [NT-1:0]          miss_req;
  logic [NT*ADDR_W-1:0]   miss_addr;
  logic [NT-1:0]          miss_busy;
  logic [NT-1:0]          miss_done;
  logic                   victim_req;
  logic [SET_W-1:0]       victim_set;
  logic [THR_W-1:0]       victim_thread;
  logic [WAY_W-1:0]       victim_way;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [ADDR_W-1:0]      mem_req_addr;
  logic [THR_W-1:0]       mem_req_thread;
  logic                   mem_rsp_valid;
  logic [THR_W-1:0]       mem_rsp_thread;
  logic [LINE_W-1:0]      mem_rsp_data;
  logic                   fill_valid;
  logic [SET_W-1:0]       fill_set;
  logic [WAY_W-1:0]       fill_way;
  logic [THR_W-1:0]       fill_thread;
  logic [TAG_W-1:0]       fill_tag;
  logic [LINE_W-1:0]      fill_data;
  logic                   rsp_err;

  // LRU model: a fixed victim way per thread, returned combinationally.
  logic [WAY_W-1:0]       way_tbl [NT];
  assign victim_way = way_tbl[victim_thread];

  cache_miss_fill_ctrl dut (
    .clock(clock), .reset(reset), .mt_mode(mt_mode),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .miss_busy(miss_busy), .miss_done(miss_done),
    .victim_req(victim_req), .victim_set(victim_set),
    .victim_thread(victim_thread), .victim_way(victim_way),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_thread(mem_req_thread),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_thread(mem_rsp_thread),
    .mem_rsp_data(mem_rsp_data),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
    .fill_thread(fill_thread), .fill_tag(fill_tag), .fill_data(fill_data),
    .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { int c; logic [SET_W-1:0] set; logic [THR_W-1:0] thr; } vic_exp_t;
  typedef struct { int c; logic [ADDR_W-1:0] addr; logic [THR_W-1:0] thr; } mem_exp_t;
  typedef struct { int c; logic [SET_W-1:0] set; logic [WAY_W-1:0] way;
                   logic [TAG_W-1:0] tag; logic [THR_W-1:0] thr;
                   logic [LINE_W-1:0] data; } fill_exp_t;

  vic_exp_t  vic_q [$];
  mem_exp_t  mem_q [$];
  fill_exp_t fill_q[$];

  localparam logic [LINE_W-1:0] D1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [LINE_W-1:0] D1B = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [LINE_W-1:0] D2A = 128'hAAAA_0000_AAAA_0000_AAAA_0000_AAAA_0000;
  localparam logic [LINE_W-1:0] D2B = 128'hBBBB_1111_BBBB_1111_BBBB_1111_BBBB_1111;
  localparam logic [LINE_W-1:0] D3A = 128'hC0DE_0001_C0DE_0002_C0DE_0003_C0DE_0004;
  localparam logic [LINE_W-1:0] D3B = 128'hD00D_0005_D00D_0006_D00D_0007_D00D_0008;
  localparam logic [LINE_W-1:0] D4  = 128'h4444_4444_0000_0000_4444_4444_0000_0000;
  localparam logic [LINE_W-1:0] D5  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [LINE_W-1:0] D6A = 128'h6666_0000_0000_0000_0000_0000_0000_6666;
  localparam logic [LINE_W-1:0] D6B = 128'h7777_0000_0000_0000_0000_0000_0000_7777;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic respond(input int c, input logic [THR_W-1:0] thr, input logic [LINE_W-1:0] d);
    wait_cyc(c);
    mem_rsp_valid  = 1'b1;
    mem_rsp_thread = thr;
    mem_rsp_data   = d;
    tick();
    mem_rsp_valid  = 1'b0;
    mem_rsp_thread = '0;
    mem_rsp_data   = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    check("reset_outputs",
          {miss_busy, miss_done, victim_req, victim_set, victim_thread,
           mem_req_valid, mem_req_addr, mem_req_thread, fill_valid, fill_set,
           fill_way, fill_thread, fill_tag, rsp_err}, 128'd0);
    check("reset_fill_data", fill_data, 128'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Monitor: compares every DUT beat against the scoreboard queues, checks
  // that stalled requests stay stable, and flags mt_mode changes while busy.
  logic                 prev_stall = 1'b0;
  logic [ADDR_W-1:0]    prev_addr  = '0;
  logic [THR_W-1:0]     prev_thr   = '0;
  multithreading_mode_t prev_mode  = SINGLE_THREADED;
  logic                 prev_busy  = 1'b0;

  always @(negedge clock) begin
    vic_exp_t  ve;
    mem_exp_t  me;
    fill_exp_t fe;

    if (victim_req) begin
      n_checks++;
      if (vic_q.size() == 0) begin
        n_fail++;
        $display("FAIL victim_unexpected: cycle %0d set %0d thread %0d, none expected",
                 cyc, victim_set, victim_thread);
      end else begin
        ve = vic_q.pop_front();
        if (cyc != ve.c || victim_set !== ve.set || victim_thread !== ve.thr) begin
          n_fail++;
          $display("FAIL victim: got cycle %0d set %0d thread %0d, expected cycle %0d set %0d thread %0d",
                   cyc, victim_set, victim_thread, ve.c, ve.set, ve.thr);
        end
      end
    end

    if (prev_stall) begin
      n_checks++;
      if (!(mem_req_valid === 1'b1 && mem_req_addr === prev_addr && mem_req_thread === prev_thr)) begin
        n_fail++;
        $display("FAIL mem_stall_stable: got valid %0b addr 0x%0h thread %0d, expected valid 1 addr 0x%0h thread %0d",
                 mem_req_valid, mem_req_addr, mem_req_thread, prev_addr, prev_thr);
      end
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr  = mem_req_addr;
    prev_thr   = mem_req_thread;

    if (mem_req_valid && mem_req_ready) begin
      n_checks++;
      if (mem_q.size() == 0) begin
        n_fail++;
        $display("FAIL mem_unexpected: cycle %0d addr 0x%0h thread %0d, none expected",
                 cyc, mem_req_addr, mem_req_thread);
      end else begin
        me = mem_q.pop_front();
        if (cyc != me.c || mem_req_addr !== me.addr || mem_req_thread !== me.thr) begin
          n_fail++;
          $display("FAIL mem_req: got cycle %0d addr 0x%0h thread %0d, expected cycle %0d addr 0x%0h thread %0d",
                   cyc, mem_req_addr, mem_req_thread, me.c, me.addr, me.thr);
        end
      end
    end

    if (fill_valid) begin
      n_checks++;
      if (fill_q.size() == 0) begin
        n_fail++;
        $display("FAIL fill_unexpected: cycle %0d set %0d thread %0d, none expected",
                 cyc, fill_set, fill_thread);
      end else begin
        fe = fill_q.pop_front();
        if (cyc != fe.c || fill_set !== fe.set || fill_way !== fe.way || fill_tag !== fe.tag ||
            fill_thread !== fe.thr || fill_data !== fe.data ||
            miss_done !== (NT'(1) << fe.thr)) begin
          n_fail++;
          $display("FAIL fill: got cycle %0d set %0d way %0d tag 0x%0h thread %0d done %b data 0x%0h, expected cycle %0d set %0d way %0d tag 0x%0h thread %0d data 0x%0h",
                   cyc, fill_set, fill_way, fill_tag, fill_thread, miss_done, fill_data,
                   fe.c, fe.set, fe.way, fe.tag, fe.thr, fe.data);
        end
      end
    end else if (miss_done !== '0) begin
      n_checks++;
      n_fail++;
      $display("FAIL miss_done_without_fill: got %b, expected 00 (cycle %0d)", miss_done, cyc);
    end

    if (mt_mode !== prev_mode) begin
      n_checks++;
      if (prev_busy) begin
        n_fail++;
        $display("FAIL mt_mode_change_while_busy: mode changed to %0d with busy set (cycle %0d)",
                 mt_mode, cyc);
      end
    end
    prev_mode = mt_mode;
    prev_busy = |miss_busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    mt_mode        = MULTI_THREADED;
    miss_req       = '0;
    miss_addr      = '0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_thread = '0;
    mem_rsp_data   = '0;
    way_tbl[0]     = 2'd2;
    way_tbl[1]     = 2'd3;

    // 1: single thread, response 5 cycles after the request, then a second
    //    miss at the earliest legal cycle, with minimum response latency.
    do_reset();
    mt_mode = SINGLE_THREADED;
    tick();
    c0 = cyc;
    miss_req = 2'b01;
    miss_addr[0 +: ADDR_W] = 32'h0000_1230;
    vic_q.push_back('{c0 + 1, 2'd3, 1'b0});
    mem_q.push_back('{c0 + 2, 32'h0000_1230, 1'b0});
    fill_q.push_back('{c0 + 8, 2'd3, 2'd2, 26'h48, 1'b0, D1});
    tick();
    miss_req = 2'b00;
    respond(c0 + 7, 1'b0, D1);
    check("t1_busy_during_fill", miss_busy, 2'b01);
    wait_cyc(c0 + 9);
    check("t1_busy_after_fill", miss_busy, 2'b00);
    c1 = cyc;
    miss_req = 2'b01;
    miss_addr[0 +: ADDR_W] = 32'h0000_0040;
    vic_q.push_back('{c1 + 1, 2'd0, 1'b0});
    mem_q.push_back('{c1 + 2, 32'h0000_0040, 1'b0});
    fill_q.push_back('{c1 + 4, 2'd0, 2'd2, 26'h1, 1'b0, D1B});
    tick();
    miss_req = 2'b00;
    respond(c1 + 3, 1'b0, D1B);
    wait_cyc(c1 + 6);

    // 2: both threads miss together; responses come back out of order and
    //    on consecutive cycles.
    do_reset();
    mt_mode = MULTI_THREADED;
    way_tbl[0] = 2'd1;
    way_tbl[1] = 2'd3;
    tick();
    c0 = cyc;
    miss_req = 2'b11;
    miss_addr = {32'h0000_3350, 32'h0000_2040};
    vic_q.push_back('{c0 + 1, 2'd0, 1'b0});
    vic_q.push_back('{c0 + 2, 2'd1, 1'b1});
    mem_q.push_back('{c0 + 2, 32'h0000_2040, 1'b0});
    mem_q.push_back('{c0 + 3, 32'h0000_3350, 1'b1});
    fill_q.push_back('{c0 + 7, 2'd1, 2'd3, 26'hCD, 1'b1, D2B});
    fill_q.push_back('{c0 + 8, 2'd0, 2'd1, 26'h81, 1'b0, D2A});
    tick();
    miss_req = 2'b00;
    respond(c0 + 6, 1'b1, D2B);
    respond(c0 + 7, 1'b0, D2A);
    wait_cyc(c0 + 10);

    // 3: mem_req_ready held low for 4 cycles while both threads want the port.
    do_reset();
    mem_req_ready = 1'b0;
    tick();
    c0 = cyc;
    miss_req = 2'b11;
    miss_addr = {32'h0000_5210, 32'h0000_4100};
    vic_q.push_back('{c0 + 1, 2'd0, 1'b0});
    vic_q.push_back('{c0 + 2, 2'd1, 1'b1});
    mem_q.push_back('{c0 + 6, 32'h0000_4100, 1'b0});
    mem_q.push_back('{c0 + 7, 32'h0000_5210, 1'b1});
    fill_q.push_back('{c0 + 9, 2'd0, 2'd1, 26'h104, 1'b0, D3A});
    fill_q.push_back('{c0 + 11, 2'd1, 2'd3, 26'h148, 1'b1, D3B});
    tick();
    miss_req = 2'b00;
    wait_cyc(c0 + 6);
    mem_req_ready = 1'b1;
    respond(c0 + 8, 1'b0, D3A);
    respond(c0 + 10, 1'b1, D3B);
    wait_cyc(c0 + 13);

    // 4: single-threaded mode ignores thread 1.
    do_reset();
    mt_mode = SINGLE_THREADED;
    way_tbl[0] = 2'd0;
    tick();
    c0 = cyc;
    miss_req = 2'b11;
    miss_addr = {32'h0000_0020, 32'h0000_0010};
    vic_q.push_back('{c0 + 1, 2'd1, 1'b0});
    mem_q.push_back('{c0 + 2, 32'h0000_0010, 1'b0});
    fill_q.push_back('{c0 + 4, 2'd1, 2'd0, 26'h0, 1'b0, D4});
    tick();
    miss_req = 2'b00;
    check("t4_busy_c1", miss_busy, 2'b01);
    tick();
    check("t4_busy_c2", miss_busy, 2'b01);
    respond(c0 + 3, 1'b0, D4);
    wait_cyc(c0 + 5);
    check("t4_busy_done", miss_busy, 2'b00);

    // 5: reset while thread 0 waits; the late response must be dropped.
    do_reset();
    mt_mode = MULTI_THREADED;
    way_tbl[0] = 2'd2;
    tick();
    c0 = cyc;
    miss_req = 2'b01;
    miss_addr = {32'h0000_0000, 32'h0000_1230};
    vic_q.push_back('{c0 + 1, 2'd3, 1'b0});
    mem_q.push_back('{c0 + 2, 32'h0000_1230, 1'b0});
    tick();
    miss_req = 2'b00;
    wait_cyc(c0 + 4);
    check("t5_busy_wait", miss_busy, 2'b01);
    do_reset();
    check("t5_err_clear", rsp_err, 1'b0);
    c1 = cyc;
    respond(c1 + 1, 1'b0, D5);
    check("t5_err_set", rsp_err, 1'b1);
    check("t5_busy_idle", miss_busy, 2'b00);
    wait_cyc(c1 + 5);
    check("t5_err_sticky", rsp_err, 1'b1);

    // 6: a fill and a victim lookup to the same set collide; the lookup is
    //    retried on the next cycle.
    do_reset();
    way_tbl[0] = 2'd1;
    way_tbl[1] = 2'd3;
    tick();
    c0 = cyc;
    miss_req = 2'b01;
    miss_addr = {32'h0000_0000, 32'h0000_0A20};
    vic_q.push_back('{c0 + 1, 2'd2, 1'b0});
    mem_q.push_back('{c0 + 2, 32'h0000_0A20, 1'b0});
    fill_q.push_back('{c0 + 5, 2'd2, 2'd1, 26'h28, 1'b0, D6A});
    vic_q.push_back('{c0 + 6, 2'd2, 1'b1});
    mem_q.push_back('{c0 + 7, 32'h0000_1E20, 1'b1});
    fill_q.push_back('{c0 + 10, 2'd2, 2'd3, 26'h78, 1'b1, D6B});
    tick();
    miss_req = 2'b00;
    wait_cyc(c0 + 4);
    miss_req       = 2'b10;
    miss_addr      = {32'h0000_1E20, 32'h0000_0A20};
    mem_rsp_valid  = 1'b1;
    mem_rsp_thread = 1'b0;
    mem_rsp_data   = D6A;
    tick();
    miss_req       = 2'b00;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    respond(c0 + 9, 1'b1, D6B);
    wait_cyc(c0 + 12);
    check("t6_err_clear", rsp_err, 1'b0);

    check("victim_queue_drained", 128'(vic_q.size()), 128'd0);
    check("mem_queue_drained", 128'(mem_q.size()), 128'd0);
    check("fill_queue_drained", 128'(fill_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
